// File: rtl/rr_ffo_arbiter_pkg.sv
// Shared types and helpers for the round-robin find-first-one arbiter.
package arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Bit idx belongs to the search window when it does not exceed the pointer.
  function automatic logic in_mask(input int unsigned idx, input int unsigned ptr);
    return idx <= ptr;
  endfunction

endpackage

// File: rtl/rr_ffo_arbiter_if.sv
// Request/grant bundle between N requesters and the round-robin arbiter.
interface rr_ffo_arbiter_if #(parameter int N = 8) ();

  logic [N-1:0]         Req;
  logic                 Release;
  logic                 GrantValid;
  logic [$clog2(N)-1:0] GrantIdx;
  logic [N-1:0]         GrantOneHot;

  modport master (output Req, Release, input GrantValid, GrantIdx, GrantOneHot);
  modport slave  (input Req, Release, output GrantValid, GrantIdx, GrantOneHot);

endinterface

// File: rtl/rr_ffo_arbiter_ffo.sv
// Find-first-one encoder: reports the highest set bit of d and whether any bit is set.
module nBitFFO #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] d,
  output logic         v,
  output logic [W-1:0] idx
);

  // Ascending scan so the last hit, the highest index, wins.
  always_comb begin
    v   = 1'b0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (d[i]) begin
        v   = 1'b1;
        idx = i[W-1:0];
      end
    end
  end

endmodule

// File: rtl/rr_ffo_arbiter.sv
// Round-robin arbiter: highest-index-first search starting at a rotating pointer,
// registered grant with optional hold-until-release.
module rr_ffo_arbiter
  import arb_pkg::*;
#(
  parameter int N    = 8,
  parameter int HOLD = 1
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  rr_ffo_arbiter_if.slave        arb
);

  localparam int W = $clog2(N);
  localparam logic [W-1:0] ONE = W'(1);

  if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_n
    $fatal(1, "rr_ffo_arbiter: N must be a power of 2 and at least 2");
  end

  arb_state_t   state_q, state_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] idx_q, idx_d;

  logic [N-1:0] mask;
  logic [N-1:0] req_masked;
  logic         v_masked, v_raw;
  logic [W-1:0] idx_masked, idx_raw;
  logic [W-1:0] win_idx;

  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) begin
      mask[i] = in_mask(i, 32'(ptr_q));
    end
  end

  assign req_masked = arb.Req & mask;

  nBitFFO #(.N(N)) u_ffo_masked (
    .d   (req_masked),
    .v   (v_masked),
    .idx (idx_masked)
  );

  nBitFFO #(.N(N)) u_ffo_raw (
    .d   (arb.Req),
    .v   (v_raw),
    .idx (idx_raw)
  );

  // Nothing at or below the pointer: wrap around to the top of the vector.
  assign win_idx = v_masked ? idx_masked : idx_raw;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    case (state_q)
      ARB_IDLE: begin
        if (v_raw) begin
          state_d = ARB_GRANT;
          idx_d   = win_idx;
          ptr_d   = win_idx - ONE;
        end
      end
      ARB_GRANT: begin
        if (HOLD != 0) begin
          if (arb.Release || !arb.Req[idx_q]) begin
            state_d = ARB_IDLE;
          end
        end else if (v_raw) begin
          idx_d = win_idx;
          ptr_d = win_idx - ONE;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '1;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
    end
  end

  assign arb.GrantValid  = (state_q == ARB_GRANT);
  assign arb.GrantIdx    = idx_q;
  assign arb.GrantOneHot = arb.GrantValid ? ({{(N-1){1'b0}}, 1'b1} << idx_q) : '0;

endmodule

// File: tb/tb_rr_ffo_arbiter.sv
// Directed-vector bench for rr_ffo_arbiter: N=8/HOLD=0, N=4/HOLD=1 and N=2/HOLD=0 instances.
module tb_rr_ffo_arbiter;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  rr_ffo_arbiter_if #(.N(8)) if8 ();
  rr_ffo_arbiter_if #(.N(4)) if4 ();
  rr_ffo_arbiter_if #(.N(2)) if2 ();

  rr_ffo_arbiter #(.N(8), .HOLD(0)) u8 (.Clock(clk), .Reset_n(rst_n), .arb(if8));
  rr_ffo_arbiter #(.N(4), .HOLD(1)) u4 (.Clock(clk), .Reset_n(rst_n), .arb(if4));
  rr_ffo_arbiter #(.N(2), .HOLD(0)) u2 (.Clock(clk), .Reset_n(rst_n), .arb(if2));

  typedef struct {
    int         sel;      // 0: N=8 HOLD=0, 1: N=4 HOLD=1, 2: N=2 HOLD=0
    logic [7:0] req;
    logic       rel;
    logic       exp_v;
    logic [2:0] exp_idx;
    logic [7:0] exp_oh;
    int         exp_ptr;  // -1 = not checked
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic vec_t mk(int sel, logic [7:0] req, logic rel, logic v,
                              logic [2:0] idx, logic [7:0] oh, int ptr);
    vec_t t;
    t.sel = sel; t.req = req; t.rel = rel; t.exp_v = v;
    t.exp_idx = idx; t.exp_oh = oh; t.exp_ptr = ptr;
    return t;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(int sel, logic [7:0] req, logic rel);
    case (sel)
      0: begin if8.Req = req;      if8.Release = rel; end
      1: begin if4.Req = req[3:0]; if4.Release = rel; end
      default: begin if2.Req = req[1:0]; if2.Release = rel; end
    endcase
  endtask

  task automatic sample(int sel, output logic v, output logic [2:0] idx,
                        output logic [7:0] oh, output int ptr);
    case (sel)
      0: begin
        v = if8.GrantValid; idx = if8.GrantIdx; oh = if8.GrantOneHot; ptr = int'(u8.ptr_q);
      end
      1: begin
        v = if4.GrantValid; idx = {1'b0, if4.GrantIdx}; oh = {4'b0, if4.GrantOneHot};
        ptr = int'(u4.ptr_q);
      end
      default: begin
        v = if2.GrantValid; idx = {2'b0, if2.GrantIdx}; oh = {6'b0, if2.GrantOneHot};
        ptr = int'(u2.ptr_q);
      end
    endcase
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, vectors=%0d", n_vec);
    $fatal(1, "timeout");
  end

  initial begin
    logic       a_v;
    logic [2:0] a_idx;
    logic [7:0] a_oh;
    int         a_ptr;

    // N=8, HOLD=0: full rotation, then wrap-and-skip, then bit 0 and wrap of the pointer.
    vecs.push_back(mk(0, 8'hFF, 0, 1, 3'd7, 8'h80, 6));
    vecs.push_back(mk(0, 8'hFF, 0, 1, 3'd6, 8'h40, 5));
    vecs.push_back(mk(0, 8'hFF, 0, 1, 3'd5, 8'h20, -1));
    vecs.push_back(mk(0, 8'hFF, 0, 1, 3'd4, 8'h10, -1));
    vecs.push_back(mk(0, 8'hFF, 0, 1, 3'd3, 8'h08, -1));
    vecs.push_back(mk(0, 8'hFF, 0, 1, 3'd2, 8'h04, -1));
    vecs.push_back(mk(0, 8'hFF, 0, 1, 3'd1, 8'h02, 0));
    vecs.push_back(mk(0, 8'hFF, 0, 1, 3'd0, 8'h01, 7));
    vecs.push_back(mk(0, 8'hFF, 0, 1, 3'd7, 8'h80, 6));
    vecs.push_back(mk(0, 8'h24, 0, 1, 3'd5, 8'h20, 4));
    vecs.push_back(mk(0, 8'h24, 0, 1, 3'd2, 8'h04, 1));
    vecs.push_back(mk(0, 8'h24, 0, 1, 3'd5, 8'h20, 4));
    vecs.push_back(mk(0, 8'h24, 0, 1, 3'd2, 8'h04, 1));
    vecs.push_back(mk(0, 8'h01, 0, 1, 3'd0, 8'h01, 7));
    vecs.push_back(mk(0, 8'h00, 0, 0, 3'd0, 8'h00, 7));
    // N=4, HOLD=1: hold through Req changes, release bubble, owner drop, idle release.
    vecs.push_back(mk(1, 8'h0A, 0, 1, 3'd3, 8'h08, 2));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(1, 8'h0E, 0, 1, 3'd3, 8'h08, 2));
    vecs.push_back(mk(1, 8'h0E, 1, 0, 3'd0, 8'h00, 2));
    vecs.push_back(mk(1, 8'h0E, 0, 1, 3'd2, 8'h04, 1));
    vecs.push_back(mk(1, 8'h02, 0, 0, 3'd0, 8'h00, 1));
    vecs.push_back(mk(1, 8'h02, 1, 1, 3'd1, 8'h02, 0));
    vecs.push_back(mk(1, 8'h00, 0, 0, 3'd0, 8'h00, 0));
    vecs.push_back(mk(1, 8'h00, 1, 0, 3'd0, 8'h00, 0));
    vecs.push_back(mk(1, 8'h01, 0, 1, 3'd0, 8'h01, 3));
    vecs.push_back(mk(1, 8'h00, 1, 0, 3'd0, 8'h00, 3));
    vecs.push_back(mk(1, 8'h08, 0, 1, 3'd3, 8'h08, 2));
    // N=2, HOLD=0: alternation.
    vecs.push_back(mk(2, 8'h03, 0, 1, 3'd1, 8'h02, 0));
    vecs.push_back(mk(2, 8'h03, 0, 1, 3'd0, 8'h01, 1));
    vecs.push_back(mk(2, 8'h03, 0, 1, 3'd1, 8'h02, 0));

    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) drive(s, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst8_valid", 32'(if8.GrantValid), 32'd0);
    check("rst8_onehot", 32'(if8.GrantOneHot), 32'd0);
    check("rst8_idx", 32'(if8.GrantIdx), 32'd0);
    check("rst8_ptr", 32'(u8.ptr_q), 32'd7);
    check("rst4_ptr", 32'(u4.ptr_q), 32'd3);
    check("rst2_ptr", 32'(u2.ptr_q), 32'd1);

    foreach (vecs[i]) begin
      drive(vecs[i].sel, vecs[i].req, vecs[i].rel);
      @(posedge clk);
      @(negedge clk);
      sample(vecs[i].sel, a_v, a_idx, a_oh, a_ptr);
      n_vec++;
      if (a_v !== vecs[i].exp_v || a_oh !== vecs[i].exp_oh ||
          (vecs[i].exp_v && a_idx !== vecs[i].exp_idx) ||
          (vecs[i].exp_ptr >= 0 && a_ptr != vecs[i].exp_ptr)) begin
        n_miss++;
        $display("FAIL vec%0d: got v=%0b idx=%0d oh=%02h ptr=%0d, expected v=%0b idx=%0d oh=%02h ptr=%0d",
                 i, a_v, a_idx, a_oh, a_ptr, vecs[i].exp_v, vecs[i].exp_idx,
                 vecs[i].exp_oh, vecs[i].exp_ptr);
      end
    end

    // Asynchronous reset while both u8 and u4 hold grants.
    drive(0, 8'hFF, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("pre_rst8_valid", 32'(if8.GrantValid), 32'd1);
    check("pre_rst4_valid", 32'(if4.GrantValid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst8_valid", 32'(if8.GrantValid), 32'd0);
    check("async_rst8_onehot", 32'(if8.GrantOneHot), 32'd0);
    check("async_rst8_ptr", 32'(u8.ptr_q), 32'd7);
    check("async_rst4_valid", 32'(if4.GrantValid), 32'd0);
    check("async_rst4_ptr", 32'(u4.ptr_q), 32'd3);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_rst8_idx", 32'(if8.GrantIdx), 32'd7);
    check("post_rst8_onehot", 32'(if8.GrantOneHot), 32'h80);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
